dac_play_x2: RTL and testbench
==============================

Name: dac_play_x2

Overview:
- BRAM-to-AXI4-Stream playback engine: reads 256-bit words from a Xilinx BRAM port and streams them out on m_axis, honouring tready backpressure.
- This is the transmit-side counterpart of the ADC capture path: the capture block fills BRAM from the stream; this block drains BRAM into the DAC/loopback stream.
- Supports one-shot and continuous-loop playback of a programmable word count.

Parameters:
- DWIDTH, 256, stream and BRAM word width in bits (multiple of 8).
- MAX_XFER, 2048, maximum words per pass; power of 2; ADDR_BITS = clog2(MAX_XFER).
- RD_LATENCY, 2, BRAM read latency in clocks (1..3).
- FIFO_DEPTH, 4, output skid FIFO depth; power of 2, must be >= RD_LATENCY+2.

Ports:
- clk_i  in  1  sole clock; also driven out on bram_clk.
- rst_i  in  1  synchronous, active-high reset.
- play_i  in  1  level; rising edge starts playback.
- stop_i  in  1  level; when high, aborts playback at the next clock.
- loop_i  in  1  sampled at start; 1 = wrap to word 0 after the last word and repeat.
- len_i  in  ADDR_BITS+1  words per pass, sampled at start; 0 or >MAX_XFER means MAX_XFER.
- done_o  out  1  high when IDLE.
- m_axis_tdata  out  DWIDTH  output word.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on the last word of each pass.
- bram_addr  out  32  byte address = {word_index, 5'b0}, upper bits 0.
- bram_en  out  1  read enable.
- bram_we  out  DWIDTH/8  tied 0.
- bram_wdata  out  DWIDTH  tied 0.
- bram_rdata  in  DWIDTH  read data, valid RD_LATENCY clocks after bram_en.
- bram_clk  out  1  = clk_i.
- bram_rst  out  1  = rst_i.

Behaviour:
- Reset values:
  - done_o = 1; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata = 0.
  - bram_en = 0; bram_addr = 0.
  - FIFO empty; in-flight count = 0; state = IDLE.
- Start:
  - play_i is registered once; start = play_q & ~play_q2, which is 2 clocks after the play_i rise.
  - Start is honoured only in IDLE; otherwise it is ignored.
  - On start: latch len_i and loop_i, clear word_index, enter RUN.
- States:
  - IDLE: no reads issued.
  - RUN: issue reads.
  - DRAIN: no new reads; wait for in-flight count = 0 and FIFO empty, then go to IDLE.
- Read issue in RUN:
  - bram_en = 1 when fifo_count + inflight < FIFO_DEPTH.
  - Each issued read carries a tag bit last = (word_index == len-1).
  - On issue, word_index increments.
  - At len-1: if loop, wrap word_index to 0 and stay in RUN; else go to DRAIN.
- Return path:
  - A RD_LATENCY-deep shift register of {valid, last} aligns with bram_rdata.
  - Aligned data is pushed into the FIFO.
  - The credit check above guarantees the FIFO never overflows; an overflow is an assertion failure.
- Output:
  - FIFO head drives tdata and tlast; tvalid = FIFO not empty.
  - Pop on tvalid & tready.
  - tdata and tlast are held stable while tvalid & ~tready (AXI rule).
- Throughput: 1 word/clock sustained with tready = 1.
- Latency: first tvalid appears RD_LATENCY+1 clocks after the RUN entry clock.
- Loop mode:
  - Output is seamless across the wrap: no bubble at word 0.
  - tlast is asserted on every pass boundary.
- stop_i:
  - From RUN, go to DRAIN the same clock; no further reads are issued.
  - Words already in flight or in the FIFO are still delivered.
  - stop_i in IDLE has no effect.
- Simultaneous events:
  - stop_i and start in the same clock: stop wins; stay IDLE.
  - rst_i overrides everything.
- Reset mid-operation: returns to reset values on the next clock. In-flight data is discarded, the FIFO is flushed, and tvalid drops even if tready = 0.
- done_o: deasserts the clock after start and reasserts the clock DRAIN completes.
- len = 1: a single word with tlast = 1; with loop, the same word repeats every clock, each with tlast = 1.

Test Plan:
- One-shot basic: BRAM word k = k, len_i = 8, loop_i = 0, tready = 1 -> exactly 8 beats with tdata 0..7, tlast only on 7. bram_addr sequence 0x00, 0x20, ..., 0xE0. done_o back to 1 after the last beat.
- Backpressure: len_i = 16, tready randomly toggled with 50% duty -> all 16 words in order with no loss or duplication. tdata is stable whenever tvalid & ~tready. The FIFO never overflows, for RD_LATENCY values 1, 2 and 3.
- Loop wrap: len_i = 4, loop_i = 1, tready = 1 for 20 beats -> tdata 0,1,2,3,0,1,... with no gaps, tlast every 4th beat. Then stop_i -> stream ends after the remaining in-flight words, then done_o = 1.
- Boundary lengths:
  - len_i = 0 -> 2048 words, bram_addr ending at 0xFFE0.
  - len_i = 1, loop_i = 0 -> a single beat with tlast = 1.
- Start/stop corner cases:
  - play_i held high -> only one pass.
  - play_i re-pulsed during RUN -> ignored.
  - stop_i and start in the same clock -> no reads issued.
- Reset mid-run: assert rst_i after 5 beats with tready = 0 -> next clock tvalid = 0, bram_en = 0, done_o = 1. A subsequent play_i then restarts from word 0.

Source files
------------

// File: rtl/dac_play_x2.sv
// BRAM-to-AXI4-Stream playback engine: drains a programmable number of words
// from a read-only BRAM port into m_axis, one-shot or looping, with tready backpressure.
module dac_play_x2 #(
  parameter int DWIDTH     = 256,
  parameter int MAX_XFER   = 2048,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int ADDR_BITS = $clog2(MAX_XFER)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  play_i,
  input  logic                  stop_i,
  input  logic                  loop_i,
  input  logic [ADDR_BITS:0]    len_i,
  output logic                  done_o,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           bram_addr,
  output logic                  bram_en,
  output logic [DWIDTH/8-1:0]   bram_we,
  output logic [DWIDTH-1:0]     bram_wdata,
  input  logic [DWIDTH-1:0]     bram_rdata,
  output logic                  bram_clk,
  output logic                  bram_rst
);

  localparam int LEN_W     = ADDR_BITS + 1;
  localparam int BYTE_BITS = $clog2(DWIDTH / 8);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int SUM_W     = CNT_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  play_q, play_q2;
  logic [ADDR_BITS-1:0]  word_q, word_d;
  logic [ADDR_BITS-1:0]  last_idx_q, last_idx_d;
  logic                  loop_q, loop_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] pipe_v_q, pipe_v_d;
  logic [RD_LATENCY-1:0] pipe_l_q, pipe_l_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [DWIDTH:0]       fifo_mem [FIFO_DEPTH];

  logic             start, issue, at_last, credit_ok, push, pop, fifo_empty;
  logic [LEN_W-1:0] len_eff;
  logic [DWIDTH:0]  head;

  assign start      = play_q & ~play_q2;
  assign len_eff    = (len_i == '0 || len_i > LEN_W'(MAX_XFER)) ? LEN_W'(MAX_XFER) : len_i;
  // Credits cover both queued words and reads whose data has not returned yet.
  assign credit_ok  = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < SUM_W'(FIFO_DEPTH);
  assign issue      = (state_q == S_RUN) && !stop_i && credit_ok;
  assign at_last    = (word_q == last_idx_q);
  assign push       = pipe_v_q[RD_LATENCY-1];
  assign fifo_empty = (fifo_cnt_q == '0);
  assign pop        = m_axis_tvalid & m_axis_tready;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d    = state_q;
    word_d     = word_q;
    last_idx_d = last_idx_q;
    loop_d     = loop_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop_i) begin
          state_d    = S_RUN;
          word_d     = '0;
          last_idx_d = ADDR_BITS'(len_eff - LEN_W'(1));
          loop_d     = loop_i;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d = S_DRAIN;
        end else if (issue) begin
          if (at_last) begin
            word_d = '0;
            if (!loop_q) state_d = S_DRAIN;
          end else begin
            word_d = word_q + ADDR_BITS'(1);
          end
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0 && fifo_empty) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pipe_v_d    = pipe_v_q;
    pipe_l_d    = pipe_l_q;
    pipe_v_d[0] = issue;
    pipe_l_d[0] = at_last;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_l_d[i] = pipe_l_q[i-1];
    end
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      play_q     <= 1'b0;
      play_q2    <= 1'b0;
      word_q     <= '0;
      last_idx_q <= '0;
      loop_q     <= 1'b0;
      inflight_q <= '0;
      pipe_v_q   <= '0;
      pipe_l_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      assert (!(push && !pop && fifo_cnt_q == CNT_W'(FIFO_DEPTH)));
      state_q    <= state_d;
      play_q     <= play_i;
      play_q2    <= play_q;
      word_q     <= word_d;
      last_idx_q <= last_idx_d;
      loop_q     <= loop_d;
      inflight_q <= inflight_d;
      pipe_v_q   <= pipe_v_d;
      pipe_l_q   <= pipe_l_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= {pipe_l_q[RD_LATENCY-1], bram_rdata};
  end

  // Head is masked while empty so tdata/tlast read zero out of reset.
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : head[DWIDTH-1:0];
  assign m_axis_tlast  = fifo_empty ? 1'b0 : head[DWIDTH];
  assign done_o        = (state_q == S_IDLE);

  assign bram_en    = issue;
  assign bram_addr  = 32'({word_q, {BYTE_BITS{1'b0}}});
  assign bram_we    = '0;
  assign bram_wdata = '0;
  assign bram_clk   = clk_i;
  assign bram_rst   = rst_i;

endmodule

// File: tb/tb_dac_play_x2.sv
// Directed bench for dac_play_x2: BRAM model holding word k = k, a negedge
// beat/address monitor, and a linear sequence of playback scenarios.
module tb_dac_play_x2;

  localparam int DW  = 256;
  localparam int RDL = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          play_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          loop_i = 1'b0;
  logic [11:0]   len_i = '0;
  logic          done_o;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [31:0]   bram_addr;
  logic          bram_en;
  logic [DW/8-1:0] bram_we;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata;
  logic          bram_clk;
  logic          bram_rst;

  dac_play_x2 #(.RD_LATENCY(RDL)) dut (
    .clk_i(clk), .rst_i(rst_i), .play_i(play_i), .stop_i(stop_i), .loop_i(loop_i),
    .len_i(len_i), .done_o(done_o), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .bram_addr(bram_addr), .bram_en(bram_en),
    .bram_we(bram_we), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .bram_clk(bram_clk), .bram_rst(bram_rst)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:2047];
  logic [DW-1:0] rd_pipe [RDL];
  always @(posedge clk) begin
    if (bram_en) rd_pipe[0] <= mem[bram_addr[15:5]];
    for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rdata = rd_pipe[RDL-1];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int unstable = 0;
  logic [DW-1:0] bd[$];
  logic          bl[$];
  int            bc[$];
  logic [31:0]   addr_log[$];
  logic          stall_q = 1'b0;
  logic [DW:0]   held;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (m_axis_tvalid && m_axis_tready) begin
        bd.push_back(m_axis_tdata);
        bl.push_back(m_axis_tlast);
        bc.push_back(cyc);
      end
      if (stall_q && m_axis_tvalid && ({m_axis_tlast, m_axis_tdata} !== held)) unstable++;
      if (bram_en) addr_log.push_back(bram_addr);
    end
    stall_q = m_axis_tvalid && !m_axis_tready && !rst_i;
    held    = {m_axis_tlast, m_axis_tdata};
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bd.delete(); bl.delete(); bc.delete(); addr_log.delete();
  endtask

  task automatic start(input int len, input logic lp);
    len_i  = 12'(len);
    loop_i = lp;
    play_i = 1'b1;
    tick(1);
    play_i = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, done_o, 1);
  endtask

  // Counts beats whose data/tlast differ from the linear sequence k, tlast on k%plen==plen-1.
  function automatic int seq_errs(input int plen);
    int e = 0;
    for (int i = 0; i < bd.size(); i++) begin
      if (bd[i] !== DW'(i % plen)) e++;
      if (bl[i] !== ((i % plen) == plen - 1)) e++;
    end
    return e;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int e;
    logic [15:0] pat;
    for (int k = 0; k < 2048; k++) mem[k] = DW'(k);

    // Reset state
    tick(3);
    chk("rst_done", done_o, 1);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_addr", bram_addr, 0);
    rst_i = 1'b0;
    tick(2);

    // One-shot len 8, including first-beat latency
    clr();
    len_i = 12'd8; loop_i = 1'b0; play_i = 1'b1;
    tick(1);
    play_i = 1'b0;
    chk("os_idle_before_start", done_o, 1);
    tick(1);
    chk("os_done_low", done_o, 0);
    chk("os_en_first", bram_en, 1);
    chk("os_addr_first", bram_addr, 0);
    tick(RDL);
    chk("os_tvalid_early", m_axis_tvalid, 0);
    tick(1);
    chk("os_tvalid_first", m_axis_tvalid, 1);
    chk("os_tdata_first", m_axis_tdata, 0);
    wait_done("os_done", 100);
    chk("os_count", bd.size(), 8);
    chk("os_seq", seq_errs(8), 0);
    chk("os_gapless", bc[bc.size()-1] - bc[0], 7);
    chk("os_addr_count", addr_log.size(), 8);
    e = 0;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] !== 32'(i * 32)) e++;
    chk("os_addr_seq", e, 0);

    // Backpressure len 16
    clr();
    pat = 16'b1011_0010_0110_1101;
    start(16, 1'b0);
    n = 0;
    while (!done_o && n < 400) begin
      m_axis_tready = pat[n % 16];
      tick(1);
      n++;
    end
    m_axis_tready = 1'b1;
    chk("bp_done", done_o, 1);
    chk("bp_count", bd.size(), 16);
    chk("bp_seq", seq_errs(16), 0);
    chk("bp_stable", unstable, 0);

    // Loop len 4: 20 beats, then stop
    clr();
    start(4, 1'b1);
    n = 0;
    while (bd.size() < 20 && n < 200) begin
      tick(1);
      n++;
    end
    chk("lp_reach20", bd.size(), 20);
    chk("lp_still_run", done_o, 0);
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    chk("lp_no_read_after_stop", bram_en, 0);
    wait_done("lp_done", 100);
    chk("lp_count", bd.size(), 20 + RDL + 1);
    chk("lp_seq", seq_errs(4), 0);
    chk("lp_gapless", bc[bc.size()-1] - bc[0], bc.size() - 1);

    // len 0 means MAX_XFER words
    clr();
    start(0, 1'b0);
    wait_done("l0_done", 2300);
    chk("l0_count", bd.size(), 2048);
    chk("l0_seq", seq_errs(2048), 0);
    chk("l0_addr_count", addr_log.size(), 2048);
    chk("l0_addr_last", addr_log[addr_log.size()-1], 32'hFFE0);
    chk("l0_gapless", bc[bc.size()-1] - bc[0], 2047);

    // len 1 one-shot
    clr();
    start(1, 1'b0);
    wait_done("l1_done", 50);
    chk("l1_count", bd.size(), 1);
    chk("l1_tdata", bd[0], 0);
    chk("l1_tlast", bl[0], 1);

    // play held high gives exactly one pass
    clr();
    len_i = 12'd3; loop_i = 1'b0; play_i = 1'b1;
    tick(2);
    chk("hold_running", done_o, 0);
    wait_done("hold_done", 50);
    tick(10);
    chk("hold_still_idle", done_o, 1);
    chk("hold_reads", addr_log.size(), 3);
    chk("hold_count", bd.size(), 3);
    play_i = 1'b0;
    tick(2);

    // play re-pulsed during RUN is ignored
    clr();
    m_axis_tready = 1'b0;
    start(8, 1'b0);
    tick(6);
    play_i = 1'b1;
    tick(1);
    play_i = 1'b0;
    tick(3);
    chk("rp_still_run", done_o, 0);
    m_axis_tready = 1'b1;
    wait_done("rp_done", 100);
    tick(10);
    chk("rp_idle_after", done_o, 1);
    chk("rp_reads", addr_log.size(), 8);
    chk("rp_seq", seq_errs(8), 0);
    chk("rp_count", bd.size(), 8);

    // stop and start in the same clock
    clr();
    len_i = 12'd4; loop_i = 1'b0; play_i = 1'b1;
    tick(1);
    stop_i = 1'b1;
    tick(1);
    stop_i = 1'b0;
    play_i = 1'b0;
    chk("ss_done", done_o, 1);
    tick(10);
    chk("ss_reads", addr_log.size(), 0);
    chk("ss_beats", bd.size(), 0);

    // Reset mid-run with tready low
    clr();
    start(16, 1'b0);
    n = 0;
    while (bd.size() < 5 && n < 100) begin
      tick(1);
      n++;
    end
    chk("mr_reach5", bd.size(), 5);
    m_axis_tready = 1'b0;
    rst_i = 1'b1;
    tick(1);
    chk("mr_tvalid", m_axis_tvalid, 0);
    chk("mr_en", bram_en, 0);
    chk("mr_done", done_o, 1);
    chk("mr_tdata", m_axis_tdata, 0);
    rst_i = 1'b0;
    m_axis_tready = 1'b1;
    tick(2);
    chk("mr_tvalid_stays_low", m_axis_tvalid, 0);
    clr();
    start(4, 1'b0);
    wait_done("mr_restart_done", 100);
    chk("mr_restart_count", bd.size(), 4);
    chk("mr_restart_seq", seq_errs(4), 0);
    chk("final_stable", unstable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
